vec_collect: RTL

- Deserializer for the scalar result stream of the dot-product/sum pipelines.
- Accepts one float per cycle under a valid/ready handshake and packs VEC_SIZE consecutive elements into one vector word.
- Presents the vector on a registered valid/ready output, so a matrix row of dot products becomes a vector for the next layer (vec_add, vec_relu, vec_dot).
- Double-buffered: a fill register plus an output holding register, giving full throughput with no bubbles.

---
 rtl/vec_collect_pkg.sv | 42 ++++
 rtl/vec_hold_reg.sv | 49 ++++
 rtl/vec_collect.sv | 131 +++++++++++++
 3 files changed

// File: rtl/vec_collect_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vec_collect_pkg
//  Description : Shared widths, helpers and constants for the vector collector
//                and its output holding register.
//  Revision    : 1.0 - initial release
// ============================================================================
package vec_collect_pkg;

    // Widest float format the zero constant covers.
    localparam int MAX_FW = 128;

    // +0.0 is all-zero bits in any IEEE-style format; slice to the needed width.
    localparam logic [MAX_FW-1:0] FLOAT_POS_ZERO = '0;

    // Total float width: sign + exponent + mantissa.
    function automatic int float_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // LSB position of a lane inside a packed vector word.
    function automatic int lane_lsb(input int lane, input int fw);
        return lane * fw;
    endfunction

    // Ceiling log2, clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int p = 1; p < value; p = p * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int cnt_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage : vec_collect_pkg
`default_nettype wire

// File: rtl/vec_hold_reg.sv
`default_nettype none
// ============================================================================
//  Module      : vec_hold_reg
//  Description : Registered valid/ready output stage. A load captures data and
//                raises valid; valid drops after a consume with no new load.
//                Data is never cleared by a consume.
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_hold_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // Next state: a load wins over a drain so drain+complete keeps valid high.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q && !ready_i;
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end
    end

    // Holding register with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule : vec_hold_reg
`default_nettype wire

// File: rtl/vec_collect.sv
`default_nettype none
// ============================================================================
//  Module      : vec_collect
//  Description : Packs VEC_SIZE consecutive scalar floats into one vector word
//                behind a registered valid/ready output. Lane 0 = first
//                arrival (LSBs). Fill register + holding register give full
//                throughput. Optional macro VEC_COLLECT_FLUSH_EN adds a flush
//                input emitting a zero-padded partial vector and an out_lanes
//                output giving the number of filled lanes.
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_collect
    import vec_collect_pkg::*;
#(
    parameter int EXP_WIDTH      = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int VEC_SIZE       = 4
) (
    input  logic                                            clk,
    input  logic                                            rst,
`ifdef VEC_COLLECT_FLUSH_EN
    input  logic                                            flush,
    output logic [clog2(VEC_SIZE+1)-1:0]                    out_lanes,
`endif
    input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]               in_data,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    output logic [VEC_SIZE*(1+EXP_WIDTH+MANTISSA_WIDTH)-1:0] out_data,
    output logic                                            out_valid,
    input  logic                                            out_ready
);

    localparam int FW      = float_width(EXP_WIDTH, MANTISSA_WIDTH);
    localparam int VW      = VEC_SIZE * FW;
    localparam int CNT_W   = cnt_width(VEC_SIZE);
    localparam int LANES_W = clog2(VEC_SIZE + 1);
`ifdef VEC_COLLECT_FLUSH_EN
    localparam int HW      = VW + LANES_W;
`else
    localparam int HW      = VW;
`endif
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(VEC_SIZE - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [VW-1:0]    fill_q, fill_d;
    logic [VW-1:0]    w_packed;
    logic [HW-1:0]    w_hold_in;
    logic [HW-1:0]    w_hold_out;
    logic             w_accept;
    logic             w_last;
    logic             w_complete;
    logic             w_load;

    assign w_last     = (count_q == LAST_LANE);
    // Stall only when the completing element would overwrite a held, non-draining vector.
    assign in_ready   = !rst && !(w_last && out_valid && !out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_complete = w_accept && w_last;

    // Fill register with the incoming element dropped into its lane.
    always_comb begin
        w_packed = fill_q;
        if (w_accept) begin
            for (int i = 0; i < VEC_SIZE; i++) begin
                if (count_q == CNT_W'(i)) begin
                    w_packed[lane_lsb(i, FW) +: FW] = in_data;
                end
            end
        end
    end

`ifdef VEC_COLLECT_FLUSH_EN
    logic [LANES_W-1:0] w_cnt_after;
    logic               w_hold_free;
    logic               w_flush_take;

    // Flush acts on the fill state after this cycle's element is packed.
    assign w_cnt_after  = LANES_W'(count_q) + LANES_W'(w_accept);
    assign w_hold_free  = !out_valid || out_ready;
    assign w_flush_take = flush && w_hold_free && !w_complete && (w_cnt_after != '0);
    assign w_load       = w_complete || w_flush_take;
    assign w_hold_in    = {(w_complete ? LANES_W'(VEC_SIZE) : w_cnt_after), w_packed};
    assign out_lanes    = w_hold_out[VW +: LANES_W];
`else
    assign w_load       = w_complete;
    assign w_hold_in    = w_packed;
`endif

    // Fill-side next state: emitting a vector restarts at lane 0 with +0.0 lanes,
    // which is what makes flushed partial vectors zero-padded.
    always_comb begin
        count_d = count_q;
        fill_d  = fill_q;
        if (w_load) begin
            count_d = '0;
            for (int i = 0; i < VEC_SIZE; i++) begin
                fill_d[lane_lsb(i, FW) +: FW] = FLOAT_POS_ZERO[FW-1:0];
            end
        end else if (w_accept) begin
            count_d = count_q + CNT_W'(1);
            fill_d  = w_packed;
        end
    end

    // Fill counter and fill register; reset discards any partial vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            fill_q  <= '0;
        end else begin
            count_q <= count_d;
            fill_q  <= fill_d;
        end
    end

    vec_hold_reg #(
        .WIDTH (HW)
    ) u_hold (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (w_load),
        .data_i  (w_hold_in),
        .ready_i (out_ready),
        .data_o  (w_hold_out),
        .valid_o (out_valid)
    );

    assign out_data = w_hold_out[VW-1:0];

endmodule : vec_collect
`default_nettype wire
